audio_slot_bit_counter: RTL and testbench
=========================================

Name: audio_slot_bit_counter

Overview:
- Parametrised successor to the audio bit counter used by the audio serialiser/deserialiser path.
- Tracks which bit clocks carry data for I2S, left-justified and TDM serial audio.
- Outputs a counting window, a down-counting bit index, a slot (channel) index, slot start/done pulses and a frame error flag.
- The shift registers in the audio in/out FIFOs consume these outputs; all inputs are single-cycle edge strobes in the clk domain.

Parameters:
DATA_WIDTH, 24, data bits per slot, 1..32
NUM_SLOTS, 2, slots per frame in TDM mode, 2..8; I2S/LJ always use 2
SLOT_BITS, 32, bit clocks per TDM slot, DATA_WIDTH..64

Ports:
clk  in  1  system clock, 50 MHz
reset  in  1  asynchronous, active-low reset; 0 = reset
bit_clk_rising_edge  in  1  one-cycle strobe, bit clock rose
bit_clk_falling_edge  in  1  one-cycle strobe, bit clock fell
left_right_clk_rising_edge  in  1  one-cycle strobe, LRCK/frame sync rose
left_right_clk_falling_edge  in  1  one-cycle strobe, LRCK/frame sync fell
mode  in  2  00 I2S, 01 left-justified, 10 TDM, 11 reserved (treated as I2S)
counting  out  1  high while current slot's data bits are on the line
bit_index  out  5  index of current data bit, MSB first, DATA_WIDTH-1 down to 0
slot_index  out  3  current slot/channel number
slot_start  out  1  one-cycle pulse, first data bit of a slot
slot_done  out  1  one-cycle pulse, last data bit of a slot consumed
frame_error  out  1  one-cycle pulse, frame event truncated a slot

Behaviour:
- All outputs are registered. Reset (reset=0, async) drives every output to 0 and the state to IDLE. Release is synchronous to clk.
- Internal state: IDLE, DELAY, DATA, PAD. Internal registers: latched mode (2 bits) and slot bit counter sbc (6 bits).
- Frame event, I2S/LJ mode:
  - LRCK falling edge starts slot 0 (left).
  - LRCK rising edge starts slot 1 (right).
- Frame event, TDM mode:
  - Only the LRCK rising edge is a frame event; it starts slot 0.
  - The LRCK falling edge is ignored.
- Mode is sampled and latched only at a frame event. Changing mode mid-frame has no effect until the next frame event.
- On a frame event:
  - Load slot_index and latched mode, set bit_index <= DATA_WIDTH-1 and sbc <= 0.
  - I2S: go to DELAY; counting stays 0.
  - LJ/TDM: go to DATA; counting <= 1 and slot_start <= 1 in the same cycle.
- DELAY: on bit_clk_falling_edge, go to DATA with counting <= 1 and slot_start <= 1. This is the I2S one-bit delay.
- DATA, on bit_clk_falling_edge:
  - If bit_index == 0: go to PAD, counting <= 0, slot_done <= 1.
  - Else: bit_index <= bit_index-1.
  - Exactly DATA_WIDTH falling edges are spent in DATA.
- PAD, I2S/LJ: hold until the next frame event. bit_clk edges are ignored and bit_index holds 0.
- TDM slot advance:
  - sbc increments on every bit_clk_falling_edge in DATA or PAD.
  - On the falling edge where sbc == SLOT_BITS-1:
    - If slot_index < NUM_SLOTS-1: slot_index++, sbc <= 0, bit_index <= DATA_WIDTH-1, state DATA, counting <= 1, slot_start <= 1.
    - Else: go to IDLE with counting 0.
  - If DATA_WIDTH == SLOT_BITS, the last-bit edge and the advance edge coincide. slot_done and slot_start then pulse in the same cycle and counting stays 1.
- frame_error:
  - Pulses when a frame event arrives while in DELAY or DATA.
  - Also pulses, in TDM, when a frame event arrives before the last slot completed (state != IDLE and not in PAD of slot NUM_SLOTS-1).
  - The new slot still starts normally; slot_done does not pulse for the truncated slot.
- Simultaneous events:
  - A frame event and bit_clk_falling_edge in the same cycle: the frame event wins and the falling edge is discarded.
  - Both LRCK edges in one cycle is illegal; the rising edge takes priority.
- bit_clk_rising_edge is unused for state. It is kept in the port list for interface compatibility.
- Reset asserted mid-slot aborts immediately: outputs go to 0 and state to IDLE. The next frame event restarts cleanly.

Test Plan:
- I2S, defaults:
  - Stimulus: LRCK fall, then 32 bit_clk falls.
  - Required: counting rises on the 1st fall with slot_index=0, bit_index=23 and slot_start. It falls on the 25th fall with slot_done. No frame_error.
- LJ, defaults:
  - Stimulus: LRCK rise.
  - Required: counting=1, slot_index=1, bit_index=23 the next cycle. bit_index reaches 0 after 23 falls. counting drops on the 24th fall.
- TDM, NUM_SLOTS=4, SLOT_BITS=32:
  - Stimulus: LRCK rise, then 128 falls.
  - Required: slot_start pulses on falls 0, 32, 64 and 96 with slot_index 0..3, four slot_done pulses, then IDLE and no error.
- Truncation, I2S:
  - Stimulus: LRCK rise after 10 data bits of slot 0.
  - Required: frame_error pulse, slot_index=1, no slot_done for slot 0, normal slot 1.
- Collision:
  - Stimulus: LRCK fall coincident with bit_clk fall, with DATA_WIDTH=SLOT_BITS=16 in TDM.
  - Required: the fall is discarded. Boundary falls give simultaneous slot_done/slot_start with counting held 1.
- Reset mid-DATA, then mode change mid-frame:
  - Required: all outputs 0 asynchronously; the new mode takes effect only at the next frame event.

Source files
------------

// File: rtl/audio_slot_bit_counter.sv
// -----------------------------------------------------------------------------
// audio_slot_bit_counter
//
// Tracks which bit clocks carry data for I2S, left-justified and TDM serial
// audio, and tells the audio FIFO shift registers when to shift and which
// bit/slot is on the line.
//
// Ports:
//   clk                          system clock
//   reset                        asynchronous, active-low reset (0 = reset)
//   bit_clk_rising_edge          one-cycle strobe, bit clock rose (unused)
//   bit_clk_falling_edge         one-cycle strobe, bit clock fell
//   left_right_clk_rising_edge   one-cycle strobe, LRCK/frame sync rose
//   left_right_clk_falling_edge  one-cycle strobe, LRCK/frame sync fell
//   mode                         00 I2S, 01 LJ, 10 TDM, 11 treated as I2S
//   counting                     high while the slot's data bits are on the line
//   bit_index                    current data bit, DATA_WIDTH-1 down to 0
//   slot_index                   current slot/channel number
//   slot_start                   pulse, first data bit of a slot
//   slot_done                    pulse, last data bit of a slot consumed
//   frame_error                  pulse, a frame event truncated a slot
// -----------------------------------------------------------------------------
module audio_slot_bit_counter #(
  parameter int DATA_WIDTH = 24,
  parameter int NUM_SLOTS  = 2,
  parameter int SLOT_BITS  = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       bit_clk_rising_edge,
  input  logic       bit_clk_falling_edge,
  input  logic       left_right_clk_rising_edge,
  input  logic       left_right_clk_falling_edge,
  input  logic [1:0] mode,
  output logic       counting,
  output logic [4:0] bit_index,
  output logic [2:0] slot_index,
  output logic       slot_start,
  output logic       slot_done,
  output logic       frame_error
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DELAY = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] PAD   = 2'd3;

  localparam logic [1:0] MODE_LJ  = 2'd1;
  localparam logic [1:0] MODE_TDM = 2'd2;

  localparam logic [4:0] BIT_MSB   = 5'(DATA_WIDTH - 1);
  localparam logic [5:0] SBC_LAST  = 6'(SLOT_BITS - 1);
  localparam logic [2:0] SLOT_LAST = 3'(NUM_SLOTS - 1);

  logic [1:0] state;
  logic [1:0] mode_q;
  logic [5:0] sbc;

  // The bit clock rising edge carries no state information here; the port
  // only exists so existing instantiations keep connecting.
  logic unused_bit_clk_rise;
  assign unused_bit_clk_rise = bit_clk_rising_edge;

  // Frame event classification uses the live mode, since that is the moment
  // the mode is sampled. In TDM only the LRCK rise marks a frame.
  logic       mode_in_tdm;
  logic       mode_in_nodelay;
  logic       frame_event;
  logic [2:0] frame_slot;
  logic       latched_tdm;
  logic       in_last_pad;
  logic       truncating;

  always_comb begin
    mode_in_tdm     = (mode == MODE_TDM);
    mode_in_nodelay = (mode == MODE_LJ) || mode_in_tdm;
    frame_event     = left_right_clk_rising_edge
                    | (left_right_clk_falling_edge & ~mode_in_tdm);
    // Rise wins if both LRCK edges arrive together (rise -> right slot).
    frame_slot      = (!mode_in_tdm && left_right_clk_rising_edge) ? 3'd1 : 3'd0;

    latched_tdm     = (mode_q == MODE_TDM);
    in_last_pad     = (state == PAD) && (slot_index == SLOT_LAST);
    truncating      = (state == DELAY) || (state == DATA)
                    || (latched_tdm && (state != IDLE) && !in_last_pad);
  end

  // NOTE: all state is updated with non-blocking assignments so every
  // register sees the pre-edge values of the others, regardless of order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      mode_q      <= 2'd0;
      sbc         <= 6'd0;
      counting    <= 1'b0;
      bit_index   <= 5'd0;
      slot_index  <= 3'd0;
      slot_start  <= 1'b0;
      slot_done   <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      slot_start  <= 1'b0;
      slot_done   <= 1'b0;
      frame_error <= 1'b0;

      if (frame_event) begin
        // A coincident bit clock fall is deliberately dropped here.
        frame_error <= truncating;
        mode_q      <= mode;
        slot_index  <= frame_slot;
        bit_index   <= BIT_MSB;
        sbc         <= 6'd0;
        if (mode_in_nodelay) begin
          state      <= DATA;
          counting   <= 1'b1;
          slot_start <= 1'b1;
        end else begin
          state    <= DELAY;
          counting <= 1'b0;
        end
      end else if (bit_clk_falling_edge) begin
        case (state)
          DELAY: begin
            state      <= DATA;
            counting   <= 1'b1;
            slot_start <= 1'b1;
          end
          DATA, PAD: begin
            if (state == DATA) begin
              if (bit_index == 5'd0) begin
                state     <= PAD;
                counting  <= 1'b0;
                slot_done <= 1'b1;
              end else begin
                bit_index <= bit_index - 5'd1;
              end
            end
            // NOTE: the slot advance below is written after the data-bit
            // update on purpose; when both land on the same edge the later
            // assignment to state/counting wins while slot_done still pulses.
            if (latched_tdm) begin
              sbc <= sbc + 6'd1;
              if (sbc == SBC_LAST) begin
                if (slot_index < SLOT_LAST) begin
                  slot_index <= slot_index + 3'd1;
                  sbc        <= 6'd0;
                  bit_index  <= BIT_MSB;
                  state      <= DATA;
                  counting   <= 1'b1;
                  slot_start <= 1'b1;
                end else begin
                  state    <= IDLE;
                  counting <= 1'b0;
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_audio_slot_bit_counter.sv
// -----------------------------------------------------------------------------
// Directed bench for audio_slot_bit_counter. Three instances share the strobe
// and reset stimulus: A uses default parameters (I2S/LJ), B is 4-slot TDM with
// 32-bit slots, C is 2-slot TDM with DATA_WIDTH == SLOT_BITS == 16.
// -----------------------------------------------------------------------------
module tb_audio_slot_bit_counter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic bre = 1'b0;
  logic bfe = 1'b0;
  logic lrr = 1'b0;
  logic lrf = 1'b0;
  logic [1:0] mode_a = 2'd0;
  logic [1:0] mode_b = 2'd2;
  logic [1:0] mode_c = 2'd2;

  logic       counting_a, slot_start_a, slot_done_a, frame_error_a;
  logic [4:0] bit_index_a;
  logic [2:0] slot_index_a;
  logic       counting_b, slot_start_b, slot_done_b, frame_error_b;
  logic [4:0] bit_index_b;
  logic [2:0] slot_index_b;
  logic       counting_c, slot_start_c, slot_done_c, frame_error_c;
  logic [4:0] bit_index_c;
  logic [2:0] slot_index_c;

  logic [11:0] pack_a, pack_b, pack_c;
  assign pack_a = {counting_a, bit_index_a, slot_index_a, slot_start_a, slot_done_a, frame_error_a};
  assign pack_b = {counting_b, bit_index_b, slot_index_b, slot_start_b, slot_done_b, frame_error_b};
  assign pack_c = {counting_c, bit_index_c, slot_index_c, slot_start_c, slot_done_c, frame_error_c};

  int checks = 0;
  int failures = 0;
  int sa, da, ea, sb, db, eb;

  always #5 clk = ~clk;

  audio_slot_bit_counter u_a (
    .clk(clk), .reset(reset),
    .bit_clk_rising_edge(bre), .bit_clk_falling_edge(bfe),
    .left_right_clk_rising_edge(lrr), .left_right_clk_falling_edge(lrf),
    .mode(mode_a),
    .counting(counting_a), .bit_index(bit_index_a), .slot_index(slot_index_a),
    .slot_start(slot_start_a), .slot_done(slot_done_a), .frame_error(frame_error_a)
  );

  audio_slot_bit_counter #(.DATA_WIDTH(24), .NUM_SLOTS(4), .SLOT_BITS(32)) u_b (
    .clk(clk), .reset(reset),
    .bit_clk_rising_edge(bre), .bit_clk_falling_edge(bfe),
    .left_right_clk_rising_edge(lrr), .left_right_clk_falling_edge(lrf),
    .mode(mode_b),
    .counting(counting_b), .bit_index(bit_index_b), .slot_index(slot_index_b),
    .slot_start(slot_start_b), .slot_done(slot_done_b), .frame_error(frame_error_b)
  );

  audio_slot_bit_counter #(.DATA_WIDTH(16), .NUM_SLOTS(2), .SLOT_BITS(16)) u_c (
    .clk(clk), .reset(reset),
    .bit_clk_rising_edge(bre), .bit_clk_falling_edge(bfe),
    .left_right_clk_rising_edge(lrr), .left_right_clk_falling_edge(lrf),
    .mode(mode_c),
    .counting(counting_c), .bit_index(bit_index_c), .slot_index(slot_index_c),
    .slot_start(slot_start_c), .slot_done(slot_done_c), .frame_error(frame_error_c)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock with the given strobes; outputs are sampled 1 ns after the edge.
  task automatic step(input logic r, input logic f, input logic b);
    lrr = r;
    lrf = f;
    bfe = b;
    bre = ~(r | f | b);
    @(posedge clk);
    #1;
    lrr = 1'b0;
    lrf = 1'b0;
    bfe = 1'b0;
    bre = 1'b0;
    sa += int'(slot_start_a);
    da += int'(slot_done_a);
    ea += int'(frame_error_a);
    sb += int'(slot_start_b);
    db += int'(slot_done_b);
    eb += int'(frame_error_b);
  endtask

  task automatic falls(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b1);
  endtask

  task automatic clear_counts();
    sa = 0; da = 0; ea = 0;
    sb = 0; db = 0; eb = 0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    clear_counts();

    // ---- asynchronous reset state ----
    #2 reset = 1'b0;
    #1;
    check("reset_a", 32'(pack_a), 0);
    check("reset_b", 32'(pack_b), 0);
    @(negedge clk);
    reset = 1'b1;

    // ---- I2S, defaults: LRCK fall then 32 bit clock falls ----
    mode_a = 2'd0;
    clear_counts();
    step(1'b0, 1'b1, 1'b0);
    check("i2s_delay_counting", 32'(counting_a), 0);
    for (int i = 1; i <= 32; i++) begin
      step(1'b0, 1'b0, 1'b1);
      if (i == 1) begin
        check("i2s_first_counting", 32'(counting_a), 1);
        check("i2s_first_slot", 32'(slot_index_a), 0);
        check("i2s_first_bit", 32'(bit_index_a), 23);
        check("i2s_first_start", 32'(slot_start_a), 1);
      end
      if (i == 24) check("i2s_last_bit", 32'(bit_index_a), 0);
      if (i == 25) begin
        check("i2s_end_counting", 32'(counting_a), 0);
        check("i2s_end_done", 32'(slot_done_a), 1);
      end
    end
    check("i2s_done_count", 32'(da), 1);
    check("i2s_no_error", 32'(ea), 0);

    // ---- LJ, defaults: LRCK rise starts slot 1 with no delay ----
    mode_a = 2'd1;
    clear_counts();
    step(1'b1, 1'b0, 1'b0);
    check("lj_start", 32'(pack_a), {1'b1, 5'd23, 3'd1, 1'b1, 1'b0, 1'b0});
    falls(23);
    check("lj_bit0", 32'({counting_a, bit_index_a}), {1'b1, 5'd0});
    step(1'b0, 1'b0, 1'b1);
    check("lj_end", 32'({counting_a, slot_done_a}), {1'b0, 1'b1});

    // ---- I2S truncation after 10 data bits of slot 0 ----
    mode_a = 2'd0;
    clear_counts();
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    falls(10);
    check("trunc_bit13", 32'(bit_index_a), 13);
    step(1'b1, 1'b0, 1'b0);
    check("trunc_error", 32'(frame_error_a), 1);
    check("trunc_state", 32'({counting_a, bit_index_a, slot_index_a}), {1'b0, 5'd23, 3'd1});
    check("trunc_no_done", 32'(da), 0);
    step(1'b0, 1'b0, 1'b1);
    check("trunc_s1_start", 32'({counting_a, slot_start_a, slot_index_a}), {1'b1, 1'b1, 3'd1});
    falls(23);
    step(1'b0, 1'b0, 1'b1);
    check("trunc_s1_done", 32'({counting_a, slot_done_a}), {1'b0, 1'b1});
    check("trunc_error_count", 32'(ea), 1);

    // ---- reset mid-DATA, then mode change mid-frame ----
    mode_a = 2'd0;
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    falls(3);
    check("mid_data", 32'({counting_a, bit_index_a}), {1'b1, 5'd20});
    reset = 1'b0;
    #1;
    check("async_reset_a", 32'(pack_a), 0);
    check("async_reset_c", 32'(pack_c), 0);
    @(negedge clk);
    reset = 1'b1;
    step(1'b0, 1'b1, 1'b0);
    check("post_reset_frame", 32'({counting_a, frame_error_a}), 0);
    mode_a = 2'd1;
    step(1'b0, 1'b0, 1'b0);
    check("mode_change_held", 32'(counting_a), 0);
    step(1'b0, 1'b0, 1'b1);
    check("latched_i2s_delay", 32'({counting_a, slot_start_a, bit_index_a}), {1'b1, 1'b1, 5'd23});
    step(1'b1, 1'b0, 1'b0);
    check("new_mode_lj", 32'({counting_a, slot_start_a, slot_index_a, frame_error_a}),
          {1'b1, 1'b1, 3'd1, 1'b1});
    mode_a = 2'd3;
    step(1'b0, 1'b1, 1'b0);
    check("mode11_as_i2s", 32'({counting_a, slot_index_a, frame_error_a}), {1'b0, 3'd0, 1'b1});

    // ---- TDM, 4 slots of 32 bits ----
    pulse_reset();
    clear_counts();
    step(1'b1, 1'b0, 1'b0);
    check("tdm_start", 32'(pack_b), {1'b1, 5'd23, 3'd0, 1'b1, 1'b0, 1'b0});
    clear_counts();
    for (int i = 1; i <= 128; i++) begin
      step(1'b0, 1'b0, 1'b1);
      if (i == 24) check("tdm_s0_done", 32'({counting_b, slot_done_b}), {1'b0, 1'b1});
      if ((i % 32) == 0 && i < 128)
        check("tdm_advance", 32'({slot_start_b, counting_b, slot_index_b}),
              {1'b1, 1'b1, 3'(i / 32)});
    end
    check("tdm_start_count", 32'(sb), 3);
    check("tdm_done_count", 32'(db), 4);
    check("tdm_no_error", 32'(eb), 0);
    check("tdm_idle", 32'({counting_b, slot_index_b}), {1'b0, 3'd3});
    step(1'b1, 1'b0, 1'b0);
    check("tdm_restart_clean", 32'({frame_error_b, slot_start_b, slot_index_b}), {1'b0, 1'b1, 3'd0});

    // ---- TDM collisions, DATA_WIDTH == SLOT_BITS == 16 ----
    pulse_reset();
    step(1'b1, 1'b0, 1'b0);
    check("col_start", 32'({counting_c, bit_index_c, slot_index_c}), {1'b1, 5'd15, 3'd0});
    falls(15);
    check("col_bit0", 32'(bit_index_c), 0);
    step(1'b0, 1'b0, 1'b1);
    check("col_boundary", 32'(pack_c), {1'b1, 5'd15, 3'd1, 1'b1, 1'b1, 1'b0});
    falls(3);
    check("col_s1_bit12", 32'(bit_index_c), 12);
    step(1'b1, 1'b0, 1'b1);
    check("col_frame_wins", 32'(pack_c), {1'b1, 5'd15, 3'd0, 1'b1, 1'b0, 1'b1});
    step(1'b0, 1'b1, 1'b1);
    check("col_tdm_fall_ignored", 32'(pack_c), {1'b1, 5'd14, 3'd0, 1'b0, 1'b0, 1'b0});
    falls(15);
    check("col_boundary2", 32'(pack_c), {1'b1, 5'd15, 3'd1, 1'b1, 1'b1, 1'b0});
    falls(16);
    check("col_last_done", 32'({counting_c, slot_done_c, slot_start_c}), {1'b0, 1'b1, 1'b0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
